// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: loads one 512-bit block and streams
// W[0..ROUNDS-1] over a valid/ready handshake, expanding words past 15 in a
// 16-entry circular buffer.
module sha256_msg_schedule #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned IDX_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic [511:0]     blk_in,
  input  logic             blk_valid,
  output logic             blk_ready,
  output logic [31:0]      w_out,
  output logic [IDX_W-1:0] w_idx,
  output logic             w_valid,
  input  logic             w_ready,
  output logic             last,
  output logic             done
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] t_q, t_d;
  logic [31:0]      w_q, w_d;
  logic             done_q, done_d;
  logic [31:0]      buf_q [16];
  logic [31:0]      buf_d [16];

  logic [IDX_W-1:0] nt;
  logic [3:0]       slot;
  logic             is_last;
  logic [31:0]      expand;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Slot nt mod 16 still holds W[nt-16]; the other taps sit at fixed offsets
  // behind it in the ring, so 4-bit wraparound indexing finds them.
  assign nt      = t_q + IDX_W'(1);
  assign slot    = nt[3:0];
  assign is_last = (t_q == IDX_W'(ROUNDS - 1));
  assign expand  = ssig1(buf_q[slot - 4'd2]) + buf_q[slot - 4'd7]
                 + ssig0(buf_q[slot - 4'd15]) + buf_q[slot];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    done_d  = 1'b0;
    buf_d   = buf_q;
    if (abort) begin
      state_d = IDLE;
      t_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (blk_valid) begin
            for (int unsigned i = 0; i < 16; i++) begin
              buf_d[i] = blk_in[511 - 32*i -: 32];
            end
            w_d     = blk_in[511:480];
            t_d     = '0;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (w_ready) begin
            if (is_last) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              t_d = nt;
              if (32'(nt) >= 32'd16) begin
                w_d         = expand;
                buf_d[slot] = expand;
              end else begin
                w_d = buf_q[slot];
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      w_q     <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      w_q     <= w_d;
      done_q  <= done_d;
      buf_q   <= buf_d;
    end
  end

  assign blk_ready = (state_q == IDLE);
  assign w_valid   = (state_q == EMIT);
  assign last      = (state_q == EMIT) && is_last;
  assign w_out     = w_q;
  assign w_idx     = t_q;
  assign done      = done_q;

endmodule
